// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank scheduler.
package led_sched_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int LED_WIDTH = 8;

  // Maps a logical pattern (1 = lit) onto the pin level.
  function automatic logic [LED_WIDTH-1:0] led_drive(input logic [LED_WIDTH-1:0] pattern,
                                                     input logic active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after start, wrapping at NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && req[IDX_W'(j)]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Time-slices the 8-LED bank between NUM_REQ pattern sources with round-robin hold-time grants.
// Optional PWM dimming is enabled by defining LED_SCHED_PWM_EN.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 13300000,
  parameter int ACTIVE_LOW  = 1,
  parameter int PWM_BITS    = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LED_WIDTH-1:0]   pattern,
  input  logic [PWM_BITS-1:0]            brightness,
  output logic [NUM_REQ-1:0]             grant,
  output logic [LED_WIDTH-1:0]           leds
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);
  localparam logic [LED_WIDTH-1:0] LEDS_OFF  = led_drive('0, ACTIVE_LOW != 0);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gidx;
  logic [CNT_W-1:0]       hold_cnt;
  logic [IDX_W-1:0]       pick_start;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic                   pwm_on;
  logic [LED_WIDTH-1:0]   lit;
  logic [LED_WIDTH-1:0]   pat_arr [NUM_REQ];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pat
    assign pat_arr[i] = pattern[i*LED_WIDTH +: LED_WIDTH];
  end

  // While holding, the search starts after the owner so the owner is considered last.
  assign pick_start = (state == HOLD) ? next_idx(gidx) : rr_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef LED_SCHED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clock) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  // All-ones brightness means fully on rather than 15/16 duty.
  assign pwm_on = (&brightness) || (pwm_cnt < brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on = 1'b1;
`endif

  assign lit = pat_arr[gidx] & {LED_WIDTH{pwm_on}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      leds     <= LEDS_OFF;
    end else begin
      case (state)
        IDLE: begin
          leds <= LEDS_OFF;
          if (pick_vld) begin
            state    <= HOLD;
            grant    <= ONE_HOT0 << pick_idx;
            gidx     <= pick_idx;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          // Release wins over expiry.
          if (!req[gidx]) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_idx(gidx);
            leds   <= LEDS_OFF;
          end else begin
            leds <= led_drive(lit, ACTIVE_LOW != 0);
            if (hold_cnt == '0) begin
              grant    <= ONE_HOT0 << pick_idx;
              gidx     <= pick_idx;
              hold_cnt <= HOLD_LOAD;
              rr_ptr   <= next_idx(pick_idx);
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Self-checking bench for led_scheduler: directed vector table, random traffic against a reference model.
module tb_led_scheduler;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'h0;
  logic [31:0] pattern = 32'h81A53C0F;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  grant;
  logic [7:0]  leds;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  led_scheduler #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1), .PWM_BITS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .pattern    (pattern),
    .brightness (brightness),
    .grant      (grant),
    .leds       (leds)
  );

  // Reference model: owner index (-1 = nobody), cycles left, search pointer, expected pins.
  int         m_owner = -1;
  int         m_left  = 0;
  int         m_ptr   = 0;
  logic [7:0] m_leds  = 8'hFF;

  function automatic int scan(input logic [3:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    logic [3:0] g;
    g = 4'h0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      m_owner = -1; m_left = 0; m_ptr = 0; m_leds = 8'hFF;
    end else if (m_owner < 0) begin
      m_leds = 8'hFF;
      w = scan(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_left = HOLD - 1; end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_leds = 8'hFF;
    end else begin
      m_leds = ~pattern[m_owner*8 +: 8];
      if (m_left == 0) begin
        w = scan(req, (m_owner + 1) % N);
        m_owner = w; m_left = HOLD - 1; m_ptr = (w + 1) % N;
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #2;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] g;
    logic [7:0] l;
  } vec_t;

  vec_t tbl[35];

  initial begin
    int   lows;
    logic onehot_ok;

    // pattern0=0F, pattern1=3C, pattern2=A5, pattern3=81 -> pins F0, C3, 5A, 7E
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 8'hFF};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 8'hFF};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 8'hFF};
    tbl[3]  = '{1'b0, 4'h5, 4'h1, 8'hFF};
    tbl[4]  = '{1'b0, 4'h5, 4'h1, 8'hF0};
    tbl[5]  = '{1'b0, 4'h5, 4'h1, 8'hF0};
    tbl[6]  = '{1'b0, 4'h5, 4'h1, 8'hF0};
    tbl[7]  = '{1'b0, 4'h5, 4'h4, 8'hF0};
    tbl[8]  = '{1'b0, 4'h5, 4'h4, 8'h5A};
    tbl[9]  = '{1'b0, 4'h5, 4'h4, 8'h5A};
    tbl[10] = '{1'b0, 4'h5, 4'h4, 8'h5A};
    tbl[11] = '{1'b0, 4'h5, 4'h1, 8'h5A};
    tbl[12] = '{1'b0, 4'h5, 4'h1, 8'hF0};
    tbl[13] = '{1'b0, 4'h2, 4'h0, 8'hFF};
    tbl[14] = '{1'b0, 4'h2, 4'h2, 8'hFF};
    tbl[15] = '{1'b0, 4'h2, 4'h2, 8'hC3};
    tbl[16] = '{1'b0, 4'h2, 4'h2, 8'hC3};
    tbl[17] = '{1'b0, 4'h2, 4'h2, 8'hC3};
    tbl[18] = '{1'b0, 4'h2, 4'h2, 8'hC3};
    tbl[19] = '{1'b0, 4'h2, 4'h2, 8'hC3};
    tbl[20] = '{1'b0, 4'h1, 4'h0, 8'hFF};
    tbl[21] = '{1'b0, 4'h1, 4'h1, 8'hFF};
    tbl[22] = '{1'b0, 4'h9, 4'h1, 8'hF0};
    tbl[23] = '{1'b0, 4'h8, 4'h0, 8'hFF};
    tbl[24] = '{1'b0, 4'h8, 4'h8, 8'hFF};
    tbl[25] = '{1'b0, 4'h8, 4'h8, 8'h7E};
    tbl[26] = '{1'b0, 4'h8, 4'h8, 8'h7E};
    tbl[27] = '{1'b0, 4'h4, 4'h0, 8'hFF};
    tbl[28] = '{1'b0, 4'h4, 4'h4, 8'hFF};
    tbl[29] = '{1'b0, 4'h4, 4'h4, 8'h5A};
    tbl[30] = '{1'b1, 4'h5, 4'h0, 8'hFF};
    tbl[31] = '{1'b0, 4'h5, 4'h1, 8'hFF};
    tbl[32] = '{1'b0, 4'h5, 4'h1, 8'hF0};
    tbl[33] = '{1'b0, 4'h0, 4'h0, 8'hFF};
    tbl[34] = '{1'b0, 4'h0, 4'h0, 8'hFF};

    @(negedge clock);
    for (int i = 0; i < 35; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].rq;
      cycle();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(tbl[i].l));
    end

    // Random traffic with live patterns and occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      pattern = $urandom;
      cycle();
      onehot_ok = (grant == 4'h0) || ($countones(grant) == 1);
      chk("rand_onehot", 32'(onehot_ok), 32'd1);
      chk("rand_grant", 32'(grant), 32'(m_grant()));
      chk("rand_leds", 32'(leds), 32'(m_leds));
    end

`ifdef LED_SCHED_PWM_EN
    reset = 1'b0;
    req = 4'h1;
    pattern = 32'h01010101;
    brightness = 4'd4;
    for (int i = 0; i < 8; i++) cycle();
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (leds[0] == 1'b0) lows++;
    end
    chk("pwm_b4_duty", 32'(lows), 32'd4);
    brightness = 4'd15;
    cycle();
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (leds[0] == 1'b0) lows++;
    end
    chk("pwm_b15_duty", 32'(lows), 32'd16);
    brightness = 4'd0;
    cycle();
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (leds[0] == 1'b0) lows++;
    end
    chk("pwm_b0_duty", 32'(lows), 32'd0);
`else
    lows = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
